// File: rtl/multi_prescaler.sv
// N-channel programmable clock divider / tick generator with shadowed, glitch-free divisor updates.
// Latency: clkout/tick are registered, one cycle behind the counter; div_err one cycle after div_wr.
// No backpressure: writes are accepted every cycle, invalid ones are dropped and flagged on div_err.
module multi_prescaler #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 32,
  parameter int F_OSC       = 25175000,
  parameter int DEFAULT_DIV = F_OSC / 1000,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                div_wr,
  input  logic [CH_W-1:0]     div_ch,
  input  logic [CNT_W-1:0]    div_val,
  output logic                div_err,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] clkout,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]    cnt     [CHANNELS];
  logic [CNT_W-1:0]    div_act [CHANNELS];
  logic [CNT_W-1:0]    shadow  [CHANNELS];
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] wr_sel;
  logic                wr_ok;

  assign wr_ok = div_wr && (int'(div_ch) < CHANNELS) && (div_val != '0);

  always_comb begin
    wrap   = '0;
    wr_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wrap[c]   = (cnt[c] == div_act[c] - CNT_W'(1));
      wr_sel[c] = wr_ok && (div_ch == CH_W'(c));
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c]     <= '0;
        div_act[c] <= DEF_DIV;
        shadow[c]  <= DEF_DIV;
      end
      pending <= '0;
      clkout  <= '0;
      tick    <= '0;
      div_err <= 1'b0;
    end else begin
      div_err <= div_wr && !wr_ok;
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync) begin
          cnt[c]    <= '0;
          clkout[c] <= 1'b0;
          tick[c]   <= 1'b0;
          if (pending[c]) begin
            div_act[c] <= shadow[c];
            pending[c] <= 1'b0;
          end
        end else if (en[c]) begin
          tick[c]   <= wrap[c];
          clkout[c] <= (cnt[c] >= (div_act[c] >> 1));
          if (wrap[c]) begin
            cnt[c] <= '0;
            if (pending[c]) begin
              div_act[c] <= shadow[c];
              pending[c] <= 1'b0;
            end
          end else begin
            cnt[c] <= cnt[c] + CNT_W'(1);
          end
        end else begin
          // Idle channel: adopt a pending divisor immediately and restart its period.
          tick[c] <= 1'b0;
          if (pending[c]) begin
            div_act[c] <= shadow[c];
            pending[c] <= 1'b0;
            cnt[c]     <= '0;
          end
        end
        // A write landing on the apply cycle is kept for the following period.
        if (wr_sel[c]) begin
          shadow[c]  <= div_val;
          pending[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_prescaler.sv
// Directed bench for multi_prescaler: cycle model feeds an expectation queue, plus fixed-pattern checks.
module tb_multi_prescaler;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DEF = 4;

  logic           clkin = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           sync;
  logic           div_wr;
  logic [1:0]     div_ch;
  logic [CW-1:0]  div_val;
  logic           div_err;
  logic [NCH-1:0] pending, clkout, tick;

  multi_prescaler #(.CHANNELS(NCH), .CNT_W(CW), .F_OSC(4000), .DEFAULT_DIV(DEF)) dut (
    .clkin(clkin), .rst_n(rst_n), .en(en), .sync(sync), .div_wr(div_wr), .div_ch(div_ch),
    .div_val(div_val), .div_err(div_err), .pending(pending), .clkout(clkout), .tick(tick)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tck;
    logic [NCH-1:0] pnd;
    logic           err;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  logic [31:0]    m_cnt [NCH];
  logic [31:0]    m_div [NCH];
  logic [31:0]    m_sh  [NCH];
  logic [NCH-1:0] m_pend, m_clk, m_tick;
  logic           m_err;

  logic [31:0] hist0;
  int tk0, tk1, both, clk1_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic ok;
    ok = div_wr && (div_ch < 2'(NCH)) && (div_val != '0);
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_div[c] = DEF; m_sh[c] = DEF;
      end
      m_pend = '0; m_clk = '0; m_tick = '0; m_err = 1'b0;
    end else begin
      m_err = div_wr && !ok;
      for (int c = 0; c < NCH; c++) begin
        if (sync) begin
          m_cnt[c] = 0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
          if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 1'b0; end
        end else if (en[c]) begin
          m_tick[c] = (m_cnt[c] == m_div[c] - 1);
          m_clk[c]  = (m_cnt[c] >= m_div[c] / 2);
          if (m_tick[c]) begin
            m_cnt[c] = 0;
            if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 1'b0; end
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end else begin
          m_tick[c] = 1'b0;
          if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 1'b0; m_cnt[c] = 0; end
        end
        if (ok && div_ch == 2'(c)) begin m_sh[c] = 32'(div_val); m_pend[c] = 1'b1; end
      end
    end
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_step();
      q.push_back('{clk: m_clk, tck: m_tick, pnd: m_pend, err: m_err});
      @(posedge clkin);
      #1;
      e = q.pop_front();
      check("clkout", 32'(clkout), 32'(e.clk));
      check("tick", 32'(tick), 32'(e.tck));
      check("pending", 32'(pending), 32'(e.pnd));
      check("div_err", 32'(div_err), 32'(e.err));
      hist0 = {hist0[30:0], clkout[0]};
      tk0 += int'(tick[0]);
      tk1 += int'(tick[1]);
      both += int'(tick[0] & tick[1]);
      clk1_low += int'(!clkout[1]);
    end
  endtask

  task automatic clear_stats();
    hist0 = '0; tk0 = 0; tk1 = 0; both = 0; clk1_low = 0;
  endtask

  task automatic write(input logic [1:0] ch, input logic [CW-1:0] val);
    div_wr = 1'b1; div_ch = ch; div_val = val;
    step(1);
    div_wr = 1'b0; div_ch = '0; div_val = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 3'b111; sync = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    clear_stats();
    step(2);
    check("reset_outputs", {29'b0, clkout | tick | pending}, 32'd0);

    // Default divisor 4: low two, high two, tick each 4th cycle
    rst_n = 1'b1;
    clear_stats();
    step(8);
    check("d4_pattern", hist0 & 32'hFF, 32'b0011_0011);
    check("d4_ticks", 32'(tk0), 32'd2);

    // Mid-period write: old period finishes, then 5-cycle period low 2 / high 3
    step(1);
    write(2'd0, 16'd5);
    check("wr_pending", 32'(pending[0]), 32'd1);
    step(2);
    check("applied_at_wrap", 32'(pending[0]), 32'd0);
    clear_stats();
    step(10);
    check("d5_pattern", hist0 & 32'h3FF, 32'b00111_00111);

    // Rejected writes
    write(2'd1, 16'd0);
    check("err_zero_val", 32'(div_err), 32'd1);
    step(1);
    check("err_clears", 32'(div_err), 32'd0);
    write(2'd3, 16'd7);
    check("err_bad_ch", 32'(div_err), 32'd1);
    check("err_no_pending", 32'(pending), 32'd0);

    // D=4 / D=6 then sync (with a simultaneous write on ch2)
    write(2'd0, 16'd4);
    write(2'd1, 16'd6);
    step(12);
    sync = 1'b1;
    write(2'd2, 16'd3);
    sync = 1'b0;
    check("sync_clk", 32'(clkout), 32'd0);
    check("sync_tick", 32'(tick), 32'd0);
    check("sync_wr_pending", 32'(pending), 32'b100);
    clear_stats();
    step(24);
    check("coincident_ticks", 32'(both), 32'd2);
    check("ch0_ticks", 32'(tk0), 32'd6);
    check("ch1_ticks", 32'(tk1), 32'd4);

    // Disable ch1 during its high phase
    step(4);
    check("ch1_high", 32'(clkout[1]), 32'd1);
    en = 3'b101;
    clear_stats();
    step(7);
    check("disabled_no_tick", 32'(tk1), 32'd0);
    check("disabled_hold_high", 32'(clk1_low), 32'd0);
    en = 3'b111;
    step(1);
    check("resume_no_tick", 32'(tick[1]), 32'd0);
    step(1);
    check("resume_tick", 32'(tick[1]), 32'd1);

    // Write D=1 exactly on ch1 wrap cycle
    step(5);
    write(2'd1, 16'd1);
    check("wrap_wr_tick", 32'(tick[1]), 32'd1);
    check("wrap_wr_pending", 32'(pending[1]), 32'd1);
    step(5);
    check("old_period_pending", 32'(pending[1]), 32'd1);
    step(1);
    check("d1_applied", 32'(pending[1]), 32'd0);
    clear_stats();
    step(5);
    check("d1_ticks", 32'(tk1), 32'd5);
    check("d1_clk_high", 32'(clk1_low), 32'd0);

    // Reset discards a pending write
    write(2'd0, 16'd9);
    check("pre_reset_pending", 32'(pending[0]), 32'd1);
    rst_n = 1'b0;
    step(1);
    check("reset_clears_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    clear_stats();
    step(8);
    check("post_reset_pattern", hist0 & 32'hFF, 32'b0011_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
